// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO arbiter slice.
//   DWIDTH_DEF / AWIDTH_DEF : default data and LIFO address widths
//   id_w()                  : width of a requester index (at least 1 bit)
//   op_e                    : LIFO operation issued in a cycle
package lifo_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 8;

  // NREQ is 2..8, so this is $clog2 with a 1-bit floor.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector.
//   req   : eligible requesters
//   ptr   : index where the search starts (highest priority this cycle)
//   grant : one-hot winner, zero when req is zero
module rr_arbiter
  import lifo_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    gnt_rot = req_rot & (-req_rot);
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    grant   = gnt_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Arbitrates NREQ requesters onto a single external LIFO (read latency 1).
//   req_push/req_pop/req_data : per-requester requests, held until granted
//   req_grant                 : one-hot, combinational in the request cycle
//   rsp_valid/rsp_id/rsp_data : pop result, one cycle after the pop grant
//   lifo_*                    : command to / status from the LIFO
//   occ                       : shadow occupancy used for eligibility
//   err_illegal/err_desync    : sticky error flags, cleared only by reset
module lifo_arbiter
  import lifo_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int AWIDTH = AWIDTH_DEF,
  parameter  int NREQ   = 2,
  localparam int IDW    = id_w(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_push,
  input  logic [NREQ-1:0]              req_pop,
  input  logic [NREQ-1:0][DWIDTH-1:0]  req_data,
  output logic [NREQ-1:0]              req_grant,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic [DWIDTH-1:0]            rsp_data,
  output logic                         lifo_wrreq,
  output logic                         lifo_rdreq,
  output logic [DWIDTH-1:0]            lifo_data,
  input  logic [DWIDTH-1:0]            lifo_q,
  input  logic                         lifo_empty,
  input  logic                         lifo_full,
  input  logic [AWIDTH:0]              lifo_usedw,
  output logic [AWIDTH:0]              occ,
  output logic                         err_illegal,
  output logic                         err_desync
);

  localparam logic [AWIDTH:0] OCC_MAX = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] OCC_ONE = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [IDW-1:0]  ID_ONE  = {{(IDW-1){1'b0}}, 1'b1};

  // rdy is low through reset and the first cycle after release; it gates
  // every grant, so async reset also kills grants combinationally.
  logic            rdy;
  logic [IDW-1:0]  rr_ptr;
  logic [AWIDTH:0] occ_d1;
  logic [NREQ-1:0] push_elig, pop_elig, arb_gnt;
  logic [IDW-1:0]  win_id;
  op_e             op;

  always_comb begin
    push_elig = (rdy && occ < OCC_MAX) ? req_push : '0;
    // A simultaneous push+pop on one requester resolves to push only.
    pop_elig  = (rdy && occ != '0) ? (req_pop & ~req_push) : '0;
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (push_elig | pop_elig),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  always_comb begin
    win_id    = '0;
    op        = OP_NONE;
    lifo_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_id = IDW'(i);
        if (req_push[i]) begin
          op        = OP_PUSH;
          lifo_data = req_data[i];
        end else begin
          op = OP_POP;
        end
      end
    end
  end

  assign req_grant  = arb_gnt;
  assign lifo_wrreq = (op == OP_PUSH);
  assign lifo_rdreq = (op == OP_POP);
  // lifo_q is only meaningful in the cycle after a read.
  assign rsp_data   = rsp_valid ? lifo_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy         <= 1'b0;
      rr_ptr      <= '0;
      occ         <= '0;
      occ_d1      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      err_illegal <= 1'b0;
      err_desync  <= 1'b0;
    end else begin
      rdy       <= 1'b1;
      occ_d1    <= occ;
      rsp_valid <= (op == OP_POP);

      if (op != OP_NONE)
        rr_ptr <= (int'(win_id) == NREQ-1) ? '0 : win_id + ID_ONE;

      case (op)
        OP_PUSH: occ <= occ + OCC_ONE;
        OP_POP:  occ <= occ - OCC_ONE;
        default: ;
      endcase

      if (op == OP_POP)
        rsp_id <= win_id;

      if (rdy && |(req_push & req_pop))
        err_illegal <= 1'b1;

      // LIFO status lags our occupancy by one cycle.
      if (rdy && ((lifo_usedw != occ_d1) ||
                  (lifo_full  && occ_d1 != OCC_MAX) ||
                  (lifo_empty && occ_d1 != '0)))
        err_desync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter (NREQ=2, AWIDTH=2, DWIDTH=16) with a
// behavioural LIFO: one-cycle read latency, usedw one cycle behind.
module tb_lifo_arbiter;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_push, req_pop;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0]          req_grant;
  logic                   rsp_valid;
  logic [0:0]             rsp_id;
  logic [DW-1:0]          rsp_data;
  logic                   lifo_wrreq, lifo_rdreq;
  logic [DW-1:0]          lifo_data, lifo_q;
  logic                   lifo_empty, lifo_full;
  logic [AW:0]            lifo_usedw;
  logic [AW:0]            occ;
  logic                   err_illegal, err_desync;
  logic                   corrupt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lifo_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
    .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .lifo_wrreq(lifo_wrreq), .lifo_rdreq(lifo_rdreq), .lifo_data(lifo_data),
    .lifo_q(lifo_q), .lifo_empty(lifo_empty), .lifo_full(lifo_full),
    .lifo_usedw(lifo_usedw),
    .occ(occ), .err_illegal(err_illegal), .err_desync(err_desync)
  );

  // Behavioural LIFO model
  logic [DW-1:0] mem [4];
  logic [2:0]    sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc         <= 3'd0;
      lifo_q     <= '0;
      lifo_usedw <= '0;
    end else begin
      lifo_usedw <= sc ^ {2'b00, corrupt};
      if (lifo_wrreq && sc != 3'd4) begin
        mem[sc[1:0]] <= lifo_data;
        sc           <= sc + 3'd1;
      end else if (lifo_rdreq && sc != 3'd0) begin
        lifo_q <= mem[sc[1:0] - 2'd1];
        sc     <= sc - 3'd1;
      end
    end
  end

  assign lifo_empty = (lifo_usedw == 3'd0);
  assign lifo_full  = (lifo_usedw == 3'd4);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  push, pop;
    logic [15:0] d0, d1;
    logic [1:0]  gnt;
    logic        wr, rd;
    logic [15:0] ldata;
    logic        rv, rid;
    logic [15:0] rdata;
    logic [2:0]  occ;
  } vec_t;

  function automatic vec_t v(logic [1:0] push, logic [1:0] pop, logic [15:0] d0,
                             logic [15:0] d1, logic [1:0] gnt, logic wr, logic rd,
                             logic [15:0] ldata, logic rv, logic rid,
                             logic [15:0] rdata, logic [2:0] occ_e);
    vec_t r;
    r.push = push; r.pop = pop; r.d0 = d0; r.d1 = d1; r.gnt = gnt;
    r.wr = wr; r.rd = rd; r.ldata = ldata; r.rv = rv; r.rid = rid;
    r.rdata = rdata; r.occ = occ_e;
    return r;
  endfunction

  vec_t tv [25];

  initial begin
    //        push   pop    d0       d1       gnt    wr rd ldata    rv rid rdata    occ
    tv[0]  = v(2'b11, 2'b00, 16'h1000, 16'h2000, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd0);
    tv[1]  = v(2'b11, 2'b00, 16'h1001, 16'h2001, 2'b01, 1, 0, 16'h1001, 0, 0, 16'h0000, 3'd0);
    tv[2]  = v(2'b11, 2'b00, 16'h1002, 16'h2002, 2'b10, 1, 0, 16'h2002, 0, 0, 16'h0000, 3'd1);
    tv[3]  = v(2'b11, 2'b00, 16'h1003, 16'h2003, 2'b01, 1, 0, 16'h1003, 0, 0, 16'h0000, 3'd2);
    tv[4]  = v(2'b11, 2'b00, 16'h1004, 16'h2004, 2'b10, 1, 0, 16'h2004, 0, 0, 16'h0000, 3'd3);
    tv[5]  = v(2'b11, 2'b00, 16'h1005, 16'h2005, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd4);
    tv[6]  = v(2'b11, 2'b00, 16'h1006, 16'h2006, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd4);
    tv[7]  = v(2'b00, 2'b10, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd4);
    tv[8]  = v(2'b00, 2'b10, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000, 1, 1, 16'h2004, 3'd3);
    tv[9]  = v(2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 1, 16'h1003, 3'd2);
    tv[10] = v(2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd2);
    tv[11] = v(2'b00, 2'b11, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd2);
    tv[12] = v(2'b00, 2'b01, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0000, 1, 0, 16'h2002, 3'd1);
    tv[13] = v(2'b00, 2'b01, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 0, 16'h1001, 3'd0);
    tv[14] = v(2'b10, 2'b01, 16'h0000, 16'h00AB, 2'b10, 1, 0, 16'h00AB, 0, 0, 16'h0000, 3'd0);
    tv[15] = v(2'b00, 2'b01, 16'h0000, 16'h0000, 2'b01, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd1);
    tv[16] = v(2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 0, 16'h00AB, 3'd0);
    tv[17] = v(2'b01, 2'b00, 16'h0011, 16'h0000, 2'b01, 1, 0, 16'h0011, 0, 0, 16'h0000, 3'd0);
    tv[18] = v(2'b10, 2'b00, 16'h0000, 16'h0022, 2'b10, 1, 0, 16'h0022, 0, 0, 16'h0000, 3'd1);
    tv[19] = v(2'b01, 2'b00, 16'h0033, 16'h0000, 2'b01, 1, 0, 16'h0033, 0, 0, 16'h0000, 3'd2);
    tv[20] = v(2'b00, 2'b10, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd3);
    tv[21] = v(2'b00, 2'b10, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000, 1, 1, 16'h0033, 3'd2);
    tv[22] = v(2'b00, 2'b10, 16'h0000, 16'h0000, 2'b10, 0, 1, 16'h0000, 1, 1, 16'h0022, 3'd1);
    tv[23] = v(2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 1, 1, 16'h0011, 3'd0);
    tv[24] = v(2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd0);

    // Reset state, with requests already asserted
    rst_n = 1'b0; corrupt = 1'b0;
    req_push = 2'b11; req_pop = 2'b00; req_data = '0;
    #2;
    chk("rst grant",  32'(req_grant),   32'h0);
    chk("rst wrreq",  32'(lifo_wrreq),  32'h0);
    chk("rst occ",    32'(occ),         32'h0);
    chk("rst rvalid", 32'(rsp_valid),   32'h0);
    chk("rst errs",   32'({err_illegal, err_desync}), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table: vector 0 falls in the first cycle after reset release
    for (int i = 0; i < 25; i++) begin
      req_push = tv[i].push; req_pop = tv[i].pop;
      req_data[0] = tv[i].d0; req_data[1] = tv[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d grant", i), 32'(req_grant),  32'(tv[i].gnt));
      chk($sformatf("v%0d wrreq", i), 32'(lifo_wrreq), 32'(tv[i].wr));
      chk($sformatf("v%0d rdreq", i), 32'(lifo_rdreq), 32'(tv[i].rd));
      if (tv[i].wr)
        chk($sformatf("v%0d ldata", i), 32'(lifo_data), 32'(tv[i].ldata));
      chk($sformatf("v%0d rvalid", i), 32'(rsp_valid), 32'(tv[i].rv));
      if (tv[i].rv)
        chk($sformatf("v%0d rid", i), 32'(rsp_id), 32'(tv[i].rid));
      chk($sformatf("v%0d rdata", i), 32'(rsp_data), 32'(tv[i].rdata));
      chk($sformatf("v%0d occ", i),   32'(occ),      32'(tv[i].occ));
      chk($sformatf("v%0d errs", i),  32'({err_illegal, err_desync}), 32'h0);
      @(posedge clk); #1;
    end

    // Push+pop on one requester: push wins, err_illegal sticks
    req_push = 2'b01; req_pop = 2'b01; req_data[0] = 16'h0055;
    @(negedge clk);
    chk("ill grant", 32'(req_grant),  32'h1);
    chk("ill wrreq", 32'(lifo_wrreq), 32'h1);
    chk("ill rdreq", 32'(lifo_rdreq), 32'h0);
    chk("ill ldata", 32'(lifo_data),  32'h55);
    @(posedge clk); #1;
    req_push = 2'b00; req_pop = 2'b00;
    chk("ill flag",  32'(err_illegal), 32'h1);
    chk("ill occ",   32'(occ),         32'h1);
    @(posedge clk); #1;
    chk("ill hold",  32'(err_illegal), 32'h1);
    chk("dsy pre",   32'(err_desync),  32'h0);
    // One corrupted usedw sample
    corrupt = 1'b1;
    @(posedge clk); #1 corrupt = 1'b0;
    @(posedge clk); #1;
    chk("dsy flag",  32'(err_desync),  32'h1);
    @(posedge clk); #1;
    chk("dsy hold",  32'(err_desync),  32'h1);
    chk("ill hold2", 32'(err_illegal), 32'h1);

    // Reset during a pop grant
    req_pop = 2'b10;
    @(negedge clk);
    chk("mid grant", 32'(req_grant),  32'h2);
    chk("mid rdreq", 32'(lifo_rdreq), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid grant0", 32'(req_grant),  32'h0);
    chk("mid rdreq0", 32'(lifo_rdreq), 32'h0);
    chk("mid occ",    32'(occ),        32'h0);
    chk("mid rvalid", 32'(rsp_valid),  32'h0);
    chk("mid errs",   32'({err_illegal, err_desync}), 32'h0);
    req_pop = 2'b00;
    @(posedge clk); #1;
    req_push = 2'b01; req_data[0] = 16'h0077;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel grant",  32'(req_grant), 32'h0);
    chk("rel rvalid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel2 grant",  32'(req_grant), 32'h1);
    chk("rel2 rvalid", 32'(rsp_valid), 32'h0);
    chk("rel2 occ",    32'(occ),       32'h0);
    @(posedge clk); #1;
    req_push = 2'b00;
    @(negedge clk);
    chk("rel3 rvalid", 32'(rsp_valid), 32'h0);
    chk("rel3 occ",    32'(occ),       32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width.
REQ-002 SHALL have parameter AWIDTH, default 8, LIFO address width; depth = 2**AWIDTH.
REQ-003 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_push  in  NREQ  per-requester push request.
REQ-007 SHALL have port req_pop  in  NREQ  per-requester pop request.
REQ-008 SHALL have port req_data  in  NREQ x DWIDTH  per-requester push word.
REQ-009 SHALL have port req_grant  out  NREQ  one-hot; request accepted this cycle.
REQ-010 SHALL have port rsp_valid  out  1  pop data valid.
REQ-011 SHALL have port rsp_id  out  clog2(NREQ)  requester owning rsp_data.
REQ-012 SHALL have port rsp_data  out  DWIDTH  popped word.
REQ-013 SHALL have ports lifo_wrreq, lifo_rdreq  out  1  and lifo_data  out  DWIDTH  LIFO command.
REQ-014 SHALL have ports lifo_q  in  DWIDTH, lifo_empty, lifo_full  in  1, lifo_usedw  in  AWIDTH+1  LIFO status.
REQ-015 SHALL have ports occ  out  AWIDTH+1  shadow occupancy, err_illegal and err_desync  out  1  sticky errors.

Function
REQ-016 SHALL issue at most one LIFO operation per cycle; lifo_wrreq and lifo_rdreq never both high.
REQ-017 SHALL treat a requester as eligible for push when req_push=1 and occ < 2**AWIDTH; for pop when req_pop=1 and req_push=0 and occ > 0.
REQ-018 SHALL resolve req_push=req_pop=1 on one requester as push only and set err_illegal.
REQ-019 SHALL grant among eligible requesters round-robin, starting search at index rr_ptr; grant is combinational in the request cycle.
REQ-020 SHALL update rr_ptr to (granted index + 1) mod NREQ on each grant; unchanged when no grant.
REQ-021 SHALL on a push grant drive lifo_wrreq=1 and lifo_data=req_data of the winner in the same cycle.
REQ-022 SHALL on a pop grant drive lifo_rdreq=1 in the same cycle and register winner id.
REQ-023 SHALL assert rsp_valid exactly one cycle after a pop grant, with rsp_id = registered id and rsp_data = lifo_q (LIFO read latency 1).
REQ-024 SHALL maintain occ: +1 per push grant, -1 per pop grant; never wraps (eligibility guarantees 0..2**AWIDTH).
REQ-025 SHALL use occ, not lifo_full/lifo_empty, for eligibility, permitting back-to-back push at occ = 2**AWIDTH-1 -> one push then stall.
REQ-026 SHALL compare lifo_usedw with occ delayed one cycle and set err_desync on mismatch; also set on lifo_full=1 with occ_d1 < 2**AWIDTH or lifo_empty=1 with occ_d1 > 0.
REQ-027 SHALL keep non-granted requests pending (requester holds until granted); no internal request queue.
REQ-028 SHALL keep err_illegal and err_desync set until reset.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force req_grant=0, lifo_wrreq=0, lifo_rdreq=0, rsp_valid=0, rsp_id=0, rsp_data=0, occ=0, rr_ptr=0, both errors=0.
REQ-030 SHALL drop any pop in flight when reset asserts mid-operation; no rsp_valid after reset release for pre-reset grants.
REQ-031 SHALL issue no grant in the first cycle after rst_n deasserts; the LIFO is reset on the same domain.

Structure
REQ-032 SHALL place DWIDTH/AWIDTH defaults, the requester-id width function, and the op enum (OP_NONE, OP_PUSH, OP_POP) in shared package lifo_pkg.
REQ-033 SHALL implement the round-robin selector as sub-module rr_arbiter (NREQ-wide request vector, pointer in, one-hot grant out).

Verification
REQ-034 SHALL cover: NREQ=2, both push every cycle from reset, data A=0x1000+n, B=0x2000+n -> grants alternate A,B,A,B; occ increments 1/cycle.
REQ-035 SHALL cover: AWIDTH=2, push 4 words then a 5th -> 5th held ungranted; occ=4; no lifo_wrreq after 4th.
REQ-036 SHALL cover: push 0x11,0x22,0x33 then req 1 pops 3 -> rsp_data 0x33,0x22,0x11, rsp_id=1, each one cycle after grant.
REQ-037 SHALL cover: occ=0, pop request -> no grant, no lifo_rdreq; after push 0xAB, pop granted next cycle, rsp_data=0xAB.
REQ-038 SHALL cover: req_push=req_pop=1 on req 0 -> push executed, err_illegal=1 until reset; forced lifo_usedw mismatch -> err_desync=1.
REQ-039 SHALL cover: rst_n low in cycle of pop grant -> outputs zero immediately; no rsp_valid after release; occ=0.
